// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the vectoring-mode CORDIC.
// Angles are Q16 radians; K is the inverse CORDIC gain for 16 micro-rotations.
package cordic_pkg;

    localparam int N_ATAN = 16;

    localparam int ATAN [0:N_ATAN-1] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

    localparam int K_Q16    = 39797;
    localparam int PI_Q16   = 205887;
    localparam int PI_2_Q16 = (PI_Q16 + 1) / 2;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER,
        SCALE,
        DONE
    } state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// Arctangent table lookup: iteration index -> atan(2^-i) in Q16.
// Indices past the end of the table return zero.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int W  = 20,
    parameter int IW = 5
) (
    input  logic [IW-1:0]       i_idx,
    output logic signed [W-1:0] o_atan
);

    always_comb begin
        // NOTE: default first so every path assigns o_atan and no latch is inferred.
        o_atan = '0;
        for (int k = 0; k < N_ATAN; k++) begin
            if (k < (1 << IW) && i_idx == IW'(k)) begin
                o_atan = W'(ATAN[k]);
            end
        end
    end

endmodule

// File: rtl/cordic_vec.sv
// Vectoring-mode CORDIC: computes atan2(y,x) and sqrt(x^2+y^2) from a Q16 vector,
// one micro-rotation per clock, behind a four-phase req/ack handshake.
module cordic_vec
    import cordic_pkg::*;
#(
    parameter int W      = 20,
    parameter int N_ITER = 16
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_req,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_y,
    output logic signed [W-1:0] o_theta,
    output logic signed [W-1:0] o_mag,
    output logic                o_ack
);

    // Three guard bits absorb the ~2.33x worst-case growth (CORDIC gain times sqrt 2).
    localparam int XW = W + 3;
    localparam int IW = $clog2(N_ITER + 1);
    localparam int PW = XW + 18;

    localparam logic signed [W-1:0]  MAG_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] MAG_MAX_EXT = PW'(MAG_MAX);
    localparam logic signed [PW-1:0] K_EXT       = PW'(K_Q16);
    localparam logic signed [W-1:0]  PI_2        = W'(PI_2_Q16);

    state_t                state_q, state_d;
    logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [W-1:0]   z_q, z_d;
    logic [IW-1:0]         i_q, i_d;
    logic                  zero_q, zero_d;
    logic signed [W-1:0]   theta_q, theta_d;
    logic signed [W-1:0]   mag_q, mag_d;
    logic                  ack_q, ack_d;

    logic signed [W-1:0]   atan_i;
    logic signed [XW-1:0]  x_sh, y_sh;
    logic signed [PW-1:0]  prod, prod_sh;
    logic signed [W-1:0]   mag_sat;

    cordic_atan_lut #(
        .W  (W),
        .IW (IW)
    ) u_atan_lut (
        .i_idx  (i_q),
        .o_atan (atan_i)
    );

    assign x_sh    = x_q >>> i_q;
    assign y_sh    = y_q >>> i_q;
    assign prod    = PW'(x_q) * K_EXT;
    assign prod_sh = prod >>> 16;

    always_comb begin
        if (prod_sh > MAG_MAX_EXT) begin
            mag_sat = MAG_MAX;
        end else if (prod_sh[PW-1]) begin
            mag_sat = '0;
        end else begin
            mag_sat = prod_sh[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        theta_d = theta_q;
        mag_d   = mag_q;
        ack_d   = ack_q;

        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    x_d     = XW'(i_x);
                    y_d     = XW'(i_y);
                    z_d     = '0;
                    i_d     = '0;
                    zero_d  = (i_x == '0) && (i_y == '0);
                    state_d = PRE;
                end
            end
            PRE: begin
                // Fold the left half-plane into |angle| <= pi/2 where CORDIC converges.
                if (x_q[XW-1] && !y_q[XW-1]) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = PI_2;
                end else if (x_q[XW-1]) begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = -PI_2;
                end else begin
                    z_d = '0;
                end
                i_d     = '0;
                state_d = ITER;
            end
            ITER: begin
                if (i_q == IW'(N_ITER)) begin
                    state_d = SCALE;
                end else begin
                    if (!y_q[XW-1]) begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_i;
                    end else begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_i;
                    end
                    i_d = i_q + IW'(1);
                end
            end
            SCALE: begin
                // A zero vector leaves y at 0 every step, so z would drift to sum(ATAN).
                theta_d = zero_q ? '0 : z_q;
                mag_d   = zero_q ? '0 : mag_sat;
                ack_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!i_req) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            theta_q <= '0;
            mag_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            theta_q <= theta_d;
            mag_q   <= mag_d;
            ack_q   <= ack_d;
        end
    end

    assign o_theta = theta_q;
    assign o_mag   = mag_q;
    assign o_ack   = ack_q;

endmodule
